// File: rtl/pulse_qualifier_pkg.sv
// Shared types and constants for the pulse qualifier.
package pulse_qualifier_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SAT   = 2'd2
  } state_t;

  // Saturation value 2^w-1 for a w-bit counter (w in 1..32).
  function automatic logic [31:0] sat_value(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/pulse_qualifier_if.sv
// Bus bundle for the pulse qualifier: channel inputs, thresholds and results.
interface pulse_qualifier_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24
);
  logic [NUM_CH-1:0]       i_in;
  logic [NUM_CH-1:0]       i_polarity;
  logic [CNT_W-1:0]        i_min;
  logic [CNT_W-1:0]        i_max;
  logic                    i_clr;
  logic [NUM_CH-1:0]       o_strobe;
  logic [NUM_CH-1:0]       o_reject;
  logic [NUM_CH*CNT_W-1:0] o_width;
  logic [NUM_CH-1:0]       o_ovf;

  modport master (
    output i_in, i_polarity, i_min, i_max, i_clr,
    input  o_strobe, o_reject, o_width, o_ovf
  );

  modport slave (
    input  i_in, i_polarity, i_min, i_max, i_clr,
    output o_strobe, o_reject, o_width, o_ovf
  );
endinterface

// File: rtl/pulse_qualifier_ch.sv
// One qualifier channel: optional input synchronizer, IDLE/COUNT/SAT FSM,
// saturating width counter and min/max evaluation at pulse end.
// Build option: PULSE_QUALIFIER_SYNC_EN adds a 2-flop synchronizer on raw.
module pulse_qualifier_ch
  import pulse_qualifier_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw,
  input  logic             pol,
  input  logic [CNT_W-1:0] min_w,
  input  logic [CNT_W-1:0] max_w,
  input  logic             clr,
  output logic             strobe,
  output logic             reject,
  output logic [CNT_W-1:0] width,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(sat_value(CNT_W));

  logic smp;
  logic act;

`ifdef PULSE_QUALIFIER_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for the asynchronous channel level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], raw};
  end

  assign smp = sync_q[1];
`else
  assign smp = raw;
`endif

  // Polarity flip makes "active" always mean 1; a polarity change simply
  // looks like a level change.
  assign act = smp ^ pol;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             end_evt;
  logic             sat_hit;
  logic             accept;

  // Next state, next count, pulse-end and saturation events.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    end_evt   = 1'b0;
    sat_hit   = 1'b0;
    accept    = (cnt >= min_w) && ((max_w == '0) || (cnt <= max_w));
    case (state)
      IDLE: begin
        if (act) begin
          cnt_nxt   = CNT_W'(1);
          state_nxt = COUNT;
          // Only reachable for a 1-bit counter.
          if (cnt_nxt == SAT_VAL) begin
            state_nxt = SAT;
            sat_hit   = 1'b1;
          end
        end
      end
      COUNT: begin
        if (act) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt_nxt == SAT_VAL) begin
            state_nxt = SAT;
            sat_hit   = 1'b1;
          end
        end else begin
          end_evt   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      SAT: begin
        // Counter holds at SAT_VAL; never wraps.
        if (!act) begin
          end_evt   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state and width counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Registered results: one-cycle strobe/reject, last width, sticky overflow
  // where a saturation in the same cycle beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe <= 1'b0;
      reject <= 1'b0;
      width  <= '0;
      ovf    <= 1'b0;
    end else begin
      strobe <= end_evt & accept;
      reject <= end_evt & ~accept;
      if (end_evt) width <= cnt;
      if (sat_hit)  ovf <= 1'b1;
      else if (clr) ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/pulse_qualifier.sv
// Multi-channel pulse width qualifier: NUM_CH independent channels sharing
// min/max thresholds and the sticky-flag clear.
// Build option: PULSE_QUALIFIER_SYNC_EN enables per-bit input synchronizers.
module pulse_qualifier #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  pulse_qualifier_if.slave   bus
);

  logic [NUM_CH-1:0] clr_fan;

  assign clr_fan = {NUM_CH{bus.i_clr}};

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    pulse_qualifier_ch #(.CNT_W(CNT_W)) u_ch (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .raw    (bus.i_in[n]),
      .pol    (bus.i_polarity[n]),
      .min_w  (bus.i_min),
      .max_w  (bus.i_max),
      .clr    (clr_fan[n]),
      .strobe (bus.o_strobe[n]),
      .reject (bus.o_reject[n]),
      .width  (bus.o_width[n*CNT_W +: CNT_W]),
      .ovf    (bus.o_ovf[n])
    );
  end

endmodule

// File: doc/pulse_qualifier.md
PULSE_QUALIFIER -- requirements
Module: pulse_qualifier

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent input channels, 1..32.
REQ-002 Parameter CNT_W, default 24: width of per-channel width counter and of thresholds.
REQ-003 Port i_clk  input  1: sole clock; all state on rising edge.
REQ-004 Port i_rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 Port i_in  input  NUM_CH: raw channel levels, one bit per channel.
REQ-006 Port i_polarity  input  NUM_CH: per channel, 0 = qualify high pulses, 1 = qualify low pulses.
REQ-007 Port i_min  input  CNT_W: minimum accepted width in cycles, shared by all channels.
REQ-008 Port i_max  input  CNT_W: maximum accepted width in cycles; 0 = no upper limit.
REQ-009 Port i_clr  input  1: synchronous clear of sticky flags.
REQ-010 Port o_strobe  output  NUM_CH: one-cycle pulse per accepted pulse.
REQ-011 Port o_reject  output  NUM_CH: one-cycle pulse per pulse outside [i_min, i_max].
REQ-012 Port o_width  output  NUM_CH*CNT_W: last measured width per channel, channel n at bits [n*CNT_W +: CNT_W].
REQ-013 Port o_ovf  output  NUM_CH: sticky flag, counter saturated on that channel.

Function
REQ-014 Active level a[n] = sampled i_in[n] XOR i_polarity[n]; sampled = after synchronizer when present (REQ-027), else i_in directly.
REQ-015 Per-channel FSM states IDLE, COUNT, SAT.
REQ-016 IDLE: counter = 0; a=1 -> COUNT, counter <= 1.
REQ-017 COUNT: a=1 -> counter +1; counter reaching 2^CNT_W-1 -> SAT, o_ovf[n] <= 1.
REQ-018 SAT: counter holds at 2^CNT_W-1; no wrap-around ever.
REQ-019 COUNT or SAT with a=0 (pulse end): evaluate counter, return to IDLE, counter <= 0, same edge.
REQ-020 Evaluation: accepted iff counter >= i_min and (i_max == 0 or counter <= i_max); accepted -> o_strobe[n]=1, else o_reject[n]=1, exactly one cycle, on the cycle after the end sample.
REQ-021 o_width slice <= counter at every pulse end, accepted or rejected; SAT end reports 2^CNT_W-1.
REQ-022 i_min/i_max sampled only at evaluation; changes mid-pulse affect only later evaluations.
REQ-023 i_polarity change mid-pulse: treated as a level change of a[n]; no special handling.
REQ-024 Back-to-back: pulse end and new active sample cannot coincide per channel; minimum one inactive cycle between pulses, still measured correctly.
REQ-025 i_clr clears all o_ovf bits; simultaneous saturation and i_clr -> o_ovf set (set wins).
REQ-026 Channels fully independent; simultaneous strobes on several channels allowed.

Reset
REQ-027 Reset value: all FSMs IDLE, counters 0, o_strobe 0, o_reject 0, o_width 0, o_ovf 0, synchronizer flops 0.
REQ-028 Reset mid-pulse discards the pulse; no strobe/reject; after release a channel already active starts from counter 1 only after a 0->1 transition of a[n] (initial "previous active" is 0, so held-active input at release counts as new pulse starting at first sample).

Configuration
REQ-029 Macro PULSE_QUALIFIER_SYNC_EN defined: 2-flop synchronizer per i_in bit, adding 2 cycles input latency (strobe 3 cycles after the raw end edge).
REQ-030 Macro undefined: no synchronizer; i_in assumed synchronous to i_clk; strobe 1 cycle after the end sample.

Structure
REQ-031 Package pulse_qualifier_pkg holds FSM state enum (IDLE, COUNT, SAT) and the saturation constant function of CNT_W.
REQ-032 Sub-module pulse_qualifier_ch: one channel (sync, FSM, counter, evaluation); top instantiates NUM_CH copies via generate and owns i_clr fan-out.

Verification (no sync, CNT_W=8, NUM_CH=4)
REQ-033 i_min=5, i_max=0, ch0 high 5 cycles -> o_strobe[0] one cycle, width 5; 4 cycles -> o_reject[0], width 4.
REQ-034 i_min=2, i_max=10, ch1 high 11 cycles -> o_reject[1], width 11; 10 cycles -> o_strobe[1].
REQ-035 ch2 high 300 cycles -> o_ovf[2] set at cycle 255, width 255, strobe if i_max=0; i_clr pulse clears o_ovf[2].
REQ-036 i_polarity[3]=1, ch3 low 6 cycles, i_min=6 -> o_strobe[3]; high pulses on ch3 ignored.
REQ-037 Reset asserted mid-pulse on ch0 -> outputs 0 immediately, no strobe after release; simultaneous ends on ch0/ch1 -> both strobes same cycle.
REQ-038 Repeat REQ-033 with PULSE_QUALIFIER_SYNC_EN -> identical widths, strobe 2 cycles later.
